// File: rtl/relay_pulse_controller.sv
// relay_pulse_controller: latching-relay coil pulse sequencer, 4 channels.
// Sequence per command: deadtime, coil pulse, contact settle, done strobe.
//
// Ports:
//   clk           in   system clock (single domain)
//   rst           in   synchronous active-high reset
//   relay_en      in   single-cycle command strobe
//   relay_dir     in   1 = set coil, 0 = reset coil (sampled with relay_en)
//   relay_channel in   [1:0] relay index (sampled with relay_en)
//   relay_done    out  one-cycle completion pulse
//   busy          out  high whenever the sequencer is not idle
//   coil_set      out  [3:0] registered set-coil drivers
//   coil_reset    out  [3:0] registered reset-coil drivers
//   relay_state   out  [3:0] last commanded state per channel (1 = set)
//
// Build option: define RELAY_STATE_TRACK_EN to track relay_state and
// skip the pulse when a channel is already in the commanded position.
// Without it relay_state reads 0 and every command pulses the coil.

module relay_pulse_controller #(
  parameter int unsigned DEADTIME_CYCLES = 188,
  parameter int unsigned PULSE_CYCLES    = 1875000,
  parameter int unsigned SETTLE_CYCLES   = 187500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       relay_en,
  input  logic       relay_dir,
  input  logic [1:0] relay_channel,
  output logic       relay_done,
  output logic       busy,
  output logic [3:0] coil_set,
  output logic [3:0] coil_reset,
  output logic [3:0] relay_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAD   = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [23:0] DEAD_LD   = 24'(DEADTIME_CYCLES - 1);
  localparam logic [23:0] PULSE_LD  = 24'(PULSE_CYCLES - 1);
  localparam logic [23:0] SETTLE_LD = 24'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  ch_q, ch_d;
  logic        dir_q, dir_d;
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_ch_q, pend_ch_d;
  logic        pend_dir_q, pend_dir_d;
  logic [3:0]  coil_set_q, coil_set_d;
  logic [3:0]  coil_reset_q, coil_reset_d;
  logic [3:0]  sel_onehot;

  // Command chosen in IDLE: a live strobe beats a waiting one.
  logic        take;
  logic [1:0]  take_ch;
  logic        take_dir;
  logic        skip;

`ifdef RELAY_STATE_TRACK_EN
  logic [3:0]  rs_q, rs_d;
`endif

  always_comb begin
    take     = relay_en | pend_v_q;
    take_ch  = relay_en ? relay_channel : pend_ch_q;
    take_dir = relay_en ? relay_dir : pend_dir_q;
`ifdef RELAY_STATE_TRACK_EN
    skip     = (rs_q[take_ch] == take_dir);
`else
    skip     = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    dir_d      = dir_q;
    pend_v_d   = pend_v_q;
    pend_ch_d  = pend_ch_q;
    pend_dir_d = pend_dir_q;

    // While busy (including DONE) a strobe parks in the slot,
    // overwriting any request that has not started yet.
    if (relay_en && state_q != IDLE) begin
      pend_v_d   = 1'b1;
      pend_ch_d  = relay_channel;
      pend_dir_d = relay_dir;
    end

    unique case (state_q)
      IDLE: begin
        if (take) begin
          pend_v_d = 1'b0;
          ch_d     = take_ch;
          dir_d    = take_dir;
          if (skip) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = DEAD;
            cnt_d   = DEAD_LD;
          end
        end
      end
      DEAD: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_onehot = '0;
    unique case (1'b1)
      (ch_d == 2'd0): sel_onehot = 4'b0001;
      (ch_d == 2'd1): sel_onehot = 4'b0010;
      (ch_d == 2'd2): sel_onehot = 4'b0100;
      default:        sel_onehot = 4'b1000;
    endcase
  end

  // Coil flops follow the next state so the drive lines up
  // exactly with the PULSE cycles and is glitch-free.
  always_comb begin
    coil_set_d   = '0;
    coil_reset_d = '0;
    if (state_d == PULSE) begin
      if (dir_d) coil_set_d   = sel_onehot;
      else       coil_reset_d = sel_onehot;
    end
  end

`ifdef RELAY_STATE_TRACK_EN
  always_comb begin
    rs_d = rs_q;
    if (state_d == DONE && state_q != DONE) begin
      rs_d[ch_d] = dir_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      dir_q        <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_ch_q    <= '0;
      pend_dir_q   <= 1'b0;
      coil_set_q   <= '0;
      coil_reset_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      dir_q        <= dir_d;
      pend_v_q     <= pend_v_d;
      pend_ch_q    <= pend_ch_d;
      pend_dir_q   <= pend_dir_d;
      coil_set_q   <= coil_set_d;
      coil_reset_q <= coil_reset_d;
    end
  end

`ifdef RELAY_STATE_TRACK_EN
  always_ff @(posedge clk) begin
    if (rst) rs_q <= '0;
    else     rs_q <= rs_d;
  end
  assign relay_state = rs_q;
`else
  assign relay_state = 4'b0000;
`endif

  assign relay_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign coil_set   = coil_set_q;
  assign coil_reset = coil_reset_q;

endmodule
